ase_mmio_responder: RTL

- AFU-side responder for CCI-P MMIO traffic.
- Accepts host-initiated MMIO write and read requests, each carrying a CfgHdr_t.
- Holds a small 64-bit CSR file and returns read completions on the TX MMIO-response channel, tagged with the request tid.
- Sits between the ASE MMIO request path and the AFU's TX2 response arbiter; it is the completer end of the MMIO request path.

---
 rtl/ase_pkg.sv | 27 ++
 rtl/ase_mmio_responder_if.sv | 30 +++
 rtl/ase_mmio_rsp_fifo.sv | 40 ++++
 rtl/ase_mmio_responder.sv | 116 +++++++++++
 4 files changed

// File: rtl/ase_pkg.sv
// Shared CCI-P MMIO types and constants for the ASE MMIO responder slice.
package ase_pkg;

  localparam int CCIP_CFG_HDR_WIDTH     = 28;
  localparam int CCIP_MMIO_TID_WIDTH    = 9;
  localparam int CCIP_MMIO_RDDATA_WIDTH = 64;

  localparam logic [1:0] MMIO_LEN_4B = 2'd0;
  localparam logic [1:0] MMIO_LEN_8B = 2'd1;

  typedef struct packed {
    logic [15:0]                    index;
    logic [1:0]                     len;
    logic                           poison;
    logic [CCIP_MMIO_TID_WIDTH-1:0] tid;
  } CfgHdr_t;

  typedef struct packed {
    logic [CCIP_MMIO_TID_WIDTH-1:0] tid;
  } MMIOHdr_t;

  typedef struct packed {
    logic [CCIP_MMIO_TID_WIDTH-1:0]    tid;
    logic [CCIP_MMIO_RDDATA_WIDTH-1:0] data;
  } mmio_rsp_t;

endpackage

// File: rtl/ase_mmio_responder_if.sv
// MMIO request / response bundle between the ASE request path and the AFU responder.
interface ase_mmio_responder_if;
  import ase_pkg::*;

  logic                              mmio_wr_valid;
  logic                              mmio_rd_valid;
  logic [CCIP_CFG_HDR_WIDTH-1:0]     mmio_hdr;
  logic [63:0]                       mmio_wrdata;
  logic                              rsp_valid;
  logic [CCIP_MMIO_TID_WIDTH-1:0]    rsp_tid;
  logic [CCIP_MMIO_RDDATA_WIDTH-1:0] rsp_data;
  logic                              rsp_ready;
  logic                              rsp_almfull;
  logic                              err_overflow;
  logic                              err_misaligned;
  logic                              err_collision;

  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, mmio_hdr, mmio_wrdata, rsp_ready,
    output rsp_valid, rsp_tid, rsp_data, rsp_almfull,
           err_overflow, err_misaligned, err_collision
  );

  modport master (
    output mmio_wr_valid, mmio_rd_valid, mmio_hdr, mmio_wrdata, rsp_ready,
    input  rsp_valid, rsp_tid, rsp_data, rsp_almfull,
           err_overflow, err_misaligned, err_collision
  );

endinterface

// File: rtl/ase_mmio_rsp_fifo.sv
// Show-ahead FIFO of MMIO read completions; push and pop may coincide.
module ase_mmio_rsp_fifo
  import ase_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  mmio_rsp_t din,
  input  logic      pop,
  output mmio_rsp_t dout,
  output logic [AW:0] count
);

  mmio_rsp_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage is not reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/ase_mmio_responder.sv
// AFU-side MMIO completer: 64-bit CSR file, one-cycle read stage, in-order
// response FIFO toward the TX MMIO-response arbiter.
module ase_mmio_responder
  import ase_pkg::*;
#(
  parameter int          NUM_CSR        = 16,
  parameter int          RSP_FIFO_DEPTH = 8,
  parameter int          ALMFULL_MARGIN = 2,
  parameter logic [63:0] AFU_ID_L       = 64'h0,
  parameter logic [63:0] AFU_ID_H       = 64'h0
) (
  input logic                 clk,
  input logic                 rst_n,
  ase_mmio_responder_if.slave mmio
);

  localparam int AW  = $clog2(RSP_FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int CIW = $clog2(NUM_CSR);

  logic [1:0]     rst_sync_q;
  logic           rst_int_n;
  CfgHdr_t        hdr;
  logic [14:0]    csr_idx;
  logic [CIW-1:0] csr_sel;
  logic           dw, in_range, is_4b;
  logic           wr_req, rd_req, misaligned, wr_en, rd_accept, pop;
  logic [63:0]    csr_q [NUM_CSR];
  logic [63:0]    csr_word, rd_word;
  logic           s1_valid;
  mmio_rsp_t      s1_rsp, head;
  logic [CW-1:0]  fifo_count, occupancy;
  logic           almfull_q, ovf_q, mis_q, col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign hdr      = CfgHdr_t'(mmio.mmio_hdr);
  assign csr_idx  = hdr.index[15:1];
  assign csr_sel  = csr_idx[CIW-1:0];
  assign dw       = hdr.index[0];
  assign in_range = csr_idx < 15'(NUM_CSR);
  assign is_4b    = hdr.len == MMIO_LEN_4B;

  assign wr_req     = mmio.mmio_wr_valid & ~mmio.mmio_rd_valid;
  assign rd_req     = mmio.mmio_rd_valid & ~mmio.mmio_wr_valid;
  assign misaligned = (wr_req | rd_req) & ~is_4b & dw;
  assign wr_en      = wr_req & ~hdr.poison & in_range & (csr_sel >= CIW'(2)) & ~(~is_4b & dw);

  // A full responder still accepts a read if the head leaves this same cycle.
  assign pop       = mmio.rsp_valid & mmio.rsp_ready;
  assign occupancy = fifo_count + CW'(s1_valid);
  assign rd_accept = rd_req & ((occupancy < CW'(RSP_FIFO_DEPTH)) | pop);

  always_comb begin
    csr_word = '0;
    for (int i = 0; i < NUM_CSR; i++) begin
      if (in_range && csr_sel == CIW'(i))
        csr_word = (i == 0) ? AFU_ID_L : (i == 1) ? AFU_ID_H : csr_q[i];
    end
    rd_word = '0;
    if (is_4b)    rd_word = dw ? {2{csr_word[63:32]}} : {2{csr_word[31:0]}};
    else if (!dw) rd_word = csr_word;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < NUM_CSR; i++) csr_q[i] <= '0;
    end else if (wr_en) begin
      if (!is_4b)   csr_q[csr_sel]        <= mmio.mmio_wrdata;
      else if (dw)  csr_q[csr_sel][63:32] <= mmio.mmio_wrdata[31:0];
      else          csr_q[csr_sel][31:0]  <= mmio.mmio_wrdata[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      s1_valid  <= 1'b0;
      s1_rsp    <= '0;
      almfull_q <= 1'b0;
      ovf_q     <= 1'b0;
      mis_q     <= 1'b0;
      col_q     <= 1'b0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) s1_rsp <= '{tid: hdr.tid, data: rd_word};
      almfull_q <= occupancy >= CW'(RSP_FIFO_DEPTH - ALMFULL_MARGIN);
      if (rd_req && !rd_accept)                   ovf_q <= 1'b1;
      if (misaligned)                             mis_q <= 1'b1;
      if (mmio.mmio_wr_valid && mmio.mmio_rd_valid) col_q <= 1'b1;
    end
  end

  ase_mmio_rsp_fifo #(.DEPTH(RSP_FIFO_DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_int_n),
    .push  (s1_valid),
    .din   (s1_rsp),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count)
  );

  // Head storage is unreset, so the payload is masked while nothing is valid.
  assign mmio.rsp_valid      = fifo_count != '0;
  assign mmio.rsp_tid        = mmio.rsp_valid ? head.tid  : '0;
  assign mmio.rsp_data       = mmio.rsp_valid ? head.data : '0;
  assign mmio.rsp_almfull    = almfull_q;
  assign mmio.err_overflow   = ovf_q;
  assign mmio.err_misaligned = mis_q;
  assign mmio.err_collision  = col_q;

endmodule
